// File: rtl/tournament_selector_if.sv
// Chooser-table bus: fetch-side lookup, resolve-side training and status.
interface tournament_selector_if #(
    parameter int unsigned IDX_W  = 12,
    parameter int unsigned HIST_W = 8
);
    logic              clear_req;
    logic [IDX_W-1:0]  lookup_addr;
    logic              choice;
    logic [HIST_W-1:0] ghr_out;
    logic              ready;
    logic              upd_valid;
    logic [IDX_W-1:0]  upd_addr;
    logic [HIST_W-1:0] upd_hist;
    logic              upd_p1_ok;
    logic              upd_p2_ok;
    logic              upd_taken;

    // Pipeline side driving lookups and training
    modport master (
        output clear_req, lookup_addr, upd_valid, upd_addr, upd_hist,
               upd_p1_ok, upd_p2_ok, upd_taken,
        input  choice, ghr_out, ready
    );

    // Chooser table
    modport slave (
        input  clear_req, lookup_addr, upd_valid, upd_addr, upd_hist,
               upd_p1_ok, upd_p2_ok, upd_taken,
        output choice, ghr_out, ready
    );
endinterface

// File: rtl/tournament_selector.sv
// Tournament chooser table: per-index saturating counters picking predictor 1 or 2,
// with an internal global history register and a self-clearing init sweep.
module tournament_selector #(
    parameter int unsigned IDX_W     = 12,
    parameter int unsigned CTR_W     = 2,
    parameter int unsigned HIST_W    = 8,
    parameter int unsigned HASH_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tournament_selector_if.slave bus
);
    localparam int unsigned DEPTH = 1 << IDX_W;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Weakly predictor 1: MSB clear, all lower bits set
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_MIN  = '0;
    localparam logic [IDX_W-1:0] PTR_LAST = '1;

    logic [CTR_W-1:0]  table_q [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q,   ptr_d;
    logic [HIST_W-1:0] ghr_q,   ghr_d;

    logic              we;
    logic [IDX_W-1:0]  waddr;
    logic [CTR_W-1:0]  wdata;

    logic              run;
    logic [IDX_W-1:0]  lookup_idx;
    logic [IDX_W-1:0]  upd_idx;
    logic [CTR_W-1:0]  lookup_ctr;
    logic [CTR_W-1:0]  upd_ctr;

    // Index hashing and table reads (read-before-write, no bypass)
    assign run        = (state_q == ST_RUN);
    assign lookup_idx = (HASH_MODE != 0) ? (bus.lookup_addr ^ IDX_W'(ghr_q)) : bus.lookup_addr;
    assign upd_idx    = (HASH_MODE != 0) ? (bus.upd_addr ^ IDX_W'(bus.upd_hist)) : bus.upd_addr;
    assign lookup_ctr = table_q[lookup_idx];
    assign upd_ctr    = table_q[upd_idx];

    // Outputs: choice is the counter MSB, forced low until the sweep has finished
    assign bus.choice  = run & lookup_ctr[CTR_W-1];
    assign bus.ready   = run;
    assign bus.ghr_out = ghr_q;

    // Next-state, sweep pointer, history and table write selection
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ghr_d   = ghr_q;
        we      = 1'b0;
        waddr   = ptr_q;
        wdata   = CTR_INIT;

        case (state_q)
            ST_INIT: begin
                if (bus.clear_req) begin
                    ptr_d = '0;
                    ghr_d = '0;
                end else begin
                    we    = 1'b1;
                    waddr = ptr_q;
                    wdata = CTR_INIT;
                    ptr_d = ptr_q + IDX_W'(1);
                    if (ptr_q == PTR_LAST) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (bus.clear_req) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                    ghr_d   = '0;
                end else if (bus.upd_valid) begin
                    ghr_d = HIST_W'({ghr_q, bus.upd_taken});
                    if (bus.upd_p2_ok && !bus.upd_p1_ok && (upd_ctr != CTR_MAX)) begin
                        we    = 1'b1;
                        waddr = upd_idx;
                        wdata = upd_ctr + CTR_W'(1);
                    end else if (bus.upd_p1_ok && !bus.upd_p2_ok && (upd_ctr != CTR_MIN)) begin
                        we    = 1'b1;
                        waddr = upd_idx;
                        wdata = upd_ctr - CTR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
                ghr_d   = '0;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
        end
    end

    // Counter storage, contents owned by the init sweep rather than reset
    always_ff @(posedge clk) begin
        if (we) begin
            table_q[waddr] <= wdata;
        end
    end
endmodule

// File: tb/tb_tournament_selector.sv
// Bench for tournament_selector: a direct-indexed and a history-hashed instance driven
// with identical stimulus and compared against a behavioural chooser model.
module tb_tournament_selector;
    logic       clk;
    logic       rst_n;
    logic       clear_req;
    logic [3:0] lookup_addr;
    logic       upd_valid;
    logic [3:0] upd_addr;
    logic [3:0] upd_hist;
    logic       upd_p1_ok;
    logic       upd_p2_ok;
    logic       upd_taken;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: [0] direct index, [1] hashed index
    int         m_tbl [2][16];
    bit         m_ready;
    int         m_left;
    logic [3:0] m_ghr;

    tournament_selector_if #(.IDX_W(4), .HIST_W(4)) if0 ();
    tournament_selector_if #(.IDX_W(4), .HIST_W(4)) if1 ();

    assign if0.clear_req = clear_req;   assign if1.clear_req = clear_req;
    assign if0.lookup_addr = lookup_addr; assign if1.lookup_addr = lookup_addr;
    assign if0.upd_valid = upd_valid;   assign if1.upd_valid = upd_valid;
    assign if0.upd_addr = upd_addr;     assign if1.upd_addr = upd_addr;
    assign if0.upd_hist = upd_hist;     assign if1.upd_hist = upd_hist;
    assign if0.upd_p1_ok = upd_p1_ok;   assign if1.upd_p1_ok = upd_p1_ok;
    assign if0.upd_p2_ok = upd_p2_ok;   assign if1.upd_p2_ok = upd_p2_ok;
    assign if0.upd_taken = upd_taken;   assign if1.upd_taken = upd_taken;

    tournament_selector #(.IDX_W(4), .CTR_W(2), .HIST_W(4), .HASH_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    tournament_selector #(.IDX_W(4), .CTR_W(2), .HIST_W(4), .HASH_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] midx(int k, logic [3:0] a, logic [3:0] h);
        return (k == 1) ? (a ^ h) : a;
    endfunction

    function automatic logic exp_choice(int k, logic [3:0] a);
        return m_ready && (m_tbl[k][midx(k, a, m_ghr)] >= 2);
    endfunction

    task automatic model_reset();
        m_ready = 1'b0;
        m_left  = 16;
        m_ghr   = 4'd0;
    endtask

    // One clock edge of the chooser rules
    task automatic model_step();
        logic [3:0] i;
        if (!m_ready) begin
            if (clear_req) m_left = 16;
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_ready = 1'b1;
                    for (int k = 0; k < 2; k++)
                        for (int e = 0; e < 16; e++) m_tbl[k][e] = 1;
                end
            end
        end else if (clear_req) begin
            m_ready = 1'b0;
            m_left  = 16;
            m_ghr   = 4'd0;
        end else if (upd_valid) begin
            for (int k = 0; k < 2; k++) begin
                i = midx(k, upd_addr, upd_hist);
                if (upd_p2_ok && !upd_p1_ok && m_tbl[k][i] < 3) m_tbl[k][i]++;
                else if (upd_p1_ok && !upd_p2_ok && m_tbl[k][i] > 0) m_tbl[k][i]--;
            end
            m_ghr = (m_ghr << 1) | 4'(upd_taken);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear_req = 1'b0; upd_valid = 1'b0; upd_addr = '0; upd_hist = '0;
        upd_p1_ok = 1'b0; upd_p2_ok = 1'b0; upd_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        lookup_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks += 4;
        if (if0.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0 got=%0b exp=0", if0.ready); end
        if (if1.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready1 got=%0b exp=0", if1.ready); end
        if (if0.ghr_out !== 4'd0) begin n_fail++; $display("FAIL reset_ghr0 got=%h exp=0", if0.ghr_out); end
        if (if1.ghr_out !== 4'd0) begin n_fail++; $display("FAIL reset_ghr1 got=%h exp=0", if1.ghr_out); end
        rst_n = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            lookup_addr = 4'($urandom);
            #1;
            n_checks += 3;
            if (if0.ready !== 1'b0 || if1.ready !== 1'b0) begin
                n_fail++; $display("FAIL init_ready cycle=%0d got=%0b/%0b exp=0", c, if0.ready, if1.ready);
            end
            if (if0.choice !== 1'b0) begin n_fail++; $display("FAIL init_choice0 cycle=%0d got=%0b exp=0", c, if0.choice); end
            if (if1.choice !== 1'b0) begin n_fail++; $display("FAIL init_choice1 cycle=%0d got=%0b exp=0", c, if1.choice); end
            tick();
        end
        n_checks += 2;
        if (if0.ready !== 1'b1) begin n_fail++; $display("FAIL ready_cycle17_0 got=%0b exp=1", if0.ready); end
        if (if1.ready !== 1'b1) begin n_fail++; $display("FAIL ready_cycle17_1 got=%0b exp=1", if1.ready); end
        for (int a = 0; a < 16; a++) begin
            lookup_addr = 4'(a);
            #1;
            n_checks += 2;
            if (if0.choice !== 1'b0) begin n_fail++; $display("FAIL swept_entry0 addr=%0d got=%0b exp=0", a, if0.choice); end
            if (if1.choice !== exp_choice(1, 4'(a))) begin
                n_fail++; $display("FAIL swept_entry1 addr=%0d got=%0b exp=%0b", a, if1.choice, exp_choice(1, 4'(a)));
            end
            tick();
        end
    endtask

    task automatic test_train();
        bit exp0 [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            upd_valid = 1'b1; upd_addr = 4'd5; upd_hist = m_ghr; upd_taken = 1'b0;
            upd_p2_ok = (i < 3); upd_p1_ok = (i >= 3);
            tick();
            upd_valid = 1'b0; lookup_addr = 4'd5;
            #1;
            n_checks += 3;
            if (if0.choice !== exp0[i]) begin n_fail++; $display("FAIL train_choice0 step=%0d got=%0b exp=%0b", i, if0.choice, exp0[i]); end
            if (if1.choice !== exp_choice(1, 4'd5)) begin
                n_fail++; $display("FAIL train_choice1 step=%0d got=%0b exp=%0b", i, if1.choice, exp_choice(1, 4'd5));
            end
            if (if0.ghr_out !== m_ghr) begin n_fail++; $display("FAIL train_ghr step=%0d got=%h exp=%h", i, if0.ghr_out, m_ghr); end
        end
    endtask

    task automatic test_hold();
        logic [3:0] g;
        for (int i = 0; i < 2; i++) begin
            g = m_ghr;
            upd_valid = 1'b1; upd_addr = 4'd7; upd_hist = m_ghr;
            upd_p1_ok = (i == 0); upd_p2_ok = (i == 0); upd_taken = (i == 0);
            tick();
            upd_valid = 1'b0; lookup_addr = 4'd7;
            #1;
            n_checks += 3;
            if (if0.choice !== 1'b0) begin n_fail++; $display("FAIL hold_choice step=%0d got=%0b exp=0", i, if0.choice); end
            if (if0.ghr_out !== ((g << 1) | 4'(i == 0))) begin
                n_fail++; $display("FAIL hold_ghr0 step=%0d got=%h exp=%h", i, if0.ghr_out, (g << 1) | 4'(i == 0));
            end
            if (if1.ghr_out !== m_ghr) begin n_fail++; $display("FAIL hold_ghr1 step=%0d got=%h exp=%h", i, if1.ghr_out, m_ghr); end
        end
    endtask

    task automatic test_hash();
        bit tk [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        upd_valid = 1'b1; upd_addr = 4'd5; upd_hist = 4'b1010;
        upd_p2_ok = 1'b1; upd_p1_ok = 1'b0; upd_taken = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            upd_addr = 4'($urandom); upd_p1_ok = 1'b1; upd_p2_ok = 1'b1; upd_taken = tk[i];
            tick();
        end
        upd_valid = 1'b0; lookup_addr = 4'h5;
        #1;
        n_checks += 4;
        if (if1.ghr_out !== 4'b1010) begin n_fail++; $display("FAIL hash_ghr got=%b exp=1010", if1.ghr_out); end
        if (if1.choice !== 1'b1) begin n_fail++; $display("FAIL hash_lookup_f got=%0b exp=1", if1.choice); end
        if (if0.choice !== exp_choice(0, 4'h5)) begin n_fail++; $display("FAIL hash_direct5 got=%0b exp=%0b", if0.choice, exp_choice(0, 4'h5)); end
        lookup_addr = 4'hA;
        #1;
        if (if1.choice !== 1'b0) begin n_fail++; $display("FAIL hash_lookup_0 got=%0b exp=0", if1.choice); end
    endtask

    task automatic test_same_cycle();
        lookup_addr = 4'd3;
        upd_valid = 1'b1; upd_addr = 4'd3; upd_hist = m_ghr;
        upd_p2_ok = 1'b1; upd_p1_ok = 1'b0; upd_taken = 1'b1;
        #1;
        n_checks += 2;
        if (if0.choice !== 1'b0) begin n_fail++; $display("FAIL same_cycle_pre0 got=%0b exp=0", if0.choice); end
        if (if1.choice !== 1'b0) begin n_fail++; $display("FAIL same_cycle_pre1 got=%0b exp=0", if1.choice); end
        tick();
        upd_valid = 1'b0;
        #1;
        n_checks += 2;
        if (if0.choice !== 1'b1) begin n_fail++; $display("FAIL same_cycle_post0 got=%0b exp=1", if0.choice); end
        if (if1.choice !== exp_choice(1, 4'd3)) begin n_fail++; $display("FAIL same_cycle_post1 got=%0b exp=%0b", if1.choice, exp_choice(1, 4'd3)); end
    endtask

    task automatic test_clear();
        clear_req = 1'b1;
        upd_valid = 1'b1; upd_addr = 4'd3; upd_hist = m_ghr;
        upd_p2_ok = 1'b1; upd_p1_ok = 1'b0; upd_taken = 1'b1;
        tick();
        clear_req = 1'b0;
        // 8 sweep cycles, a restarting clear, then a full 16-cycle sweep
        for (int c = 0; c < 25; c++) begin
            upd_valid = 1'b1; upd_addr = 4'($urandom); upd_taken = 1'b1;
            clear_req = (c == 8);
            #1;
            n_checks += 2;
            if (if0.ready !== 1'b0 || if1.ready !== 1'b0) begin
                n_fail++; $display("FAIL clear_ready cycle=%0d got=%0b/%0b exp=0", c, if0.ready, if1.ready);
            end
            if (if0.ghr_out !== 4'd0 || if1.ghr_out !== 4'd0) begin
                n_fail++; $display("FAIL clear_ghr cycle=%0d got=%h/%h exp=0", c, if0.ghr_out, if1.ghr_out);
            end
            tick();
        end
        idle_inputs();
        #1;
        n_checks++;
        if (if0.ready !== 1'b1 || if1.ready !== 1'b1) begin
            n_fail++; $display("FAIL clear_ready_done got=%0b/%0b exp=1", if0.ready, if1.ready);
        end
        for (int a = 0; a < 16; a++) begin
            lookup_addr = 4'(a);
            #1;
            n_checks++;
            if (if0.choice !== 1'b0 || if1.choice !== 1'b0) begin
                n_fail++; $display("FAIL clear_entry addr=%0d got=%0b/%0b exp=0", a, if0.choice, if1.choice);
            end
            tick();
        end
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 3; i++) begin
            upd_valid = 1'b1; upd_hist = m_ghr; upd_taken = 1'b1; upd_p1_ok = 1'b0; upd_p2_ok = 1'b0;
            tick();
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks += 2;
        if (if0.ready !== 1'b0 || if1.ready !== 1'b0) begin n_fail++; $display("FAIL rst_run_ready got=%0b/%0b exp=0", if0.ready, if1.ready); end
        if (if0.ghr_out !== 4'd0 || if1.ghr_out !== 4'd0) begin n_fail++; $display("FAIL rst_run_ghr got=%h/%h exp=0", if0.ghr_out, if1.ghr_out); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            #1;
            n_checks++;
            if (if0.ready !== 1'b0 || if1.ready !== 1'b0) begin
                n_fail++; $display("FAIL rst_sweep_ready cycle=%0d got=%0b/%0b exp=0", c, if0.ready, if1.ready);
            end
            tick();
        end
        n_checks++;
        if (if0.ready !== 1'b1 || if1.ready !== 1'b1) begin n_fail++; $display("FAIL rst_sweep_done got=%0b/%0b exp=1", if0.ready, if1.ready); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            clear_req   = ($urandom_range(0, 63) == 0);
            upd_valid   = ($urandom_range(0, 3) != 0);
            upd_addr    = 4'($urandom);
            upd_hist    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : m_ghr;
            upd_p1_ok   = 1'($urandom);
            upd_p2_ok   = 1'($urandom);
            upd_taken   = 1'($urandom);
            lookup_addr = 4'($urandom);
            #1;
            n_checks += 3;
            if (if0.choice !== exp_choice(0, lookup_addr) || if1.choice !== exp_choice(1, lookup_addr)) begin
                n_fail++;
                $display("FAIL rand_choice cycle=%0d addr=%h got=%0b/%0b exp=%0b/%0b", c, lookup_addr,
                         if0.choice, if1.choice, exp_choice(0, lookup_addr), exp_choice(1, lookup_addr));
            end
            if (if0.ready !== m_ready || if1.ready !== m_ready) begin
                n_fail++; $display("FAIL rand_ready cycle=%0d got=%0b/%0b exp=%0b", c, if0.ready, if1.ready, m_ready);
            end
            if (if0.ghr_out !== m_ghr || if1.ghr_out !== m_ghr) begin
                n_fail++; $display("FAIL rand_ghr cycle=%0d got=%h/%h exp=%h", c, if0.ghr_out, if1.ghr_out, m_ghr);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_train();
        test_hold();
        test_hash();
        test_same_cycle();
        test_clear();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
